bcd_convert_seq: RTL and testbench

- Sequential double-dabble binary-to-BCD converter for the frequency counter display path.
- Replaces a fully unrolled combinational converter with one shared shift/add-3 datapath, iterated once per clock under FSM control.
- Sits between the count latch (binary result) and the display driver, with a start/busy/done handshake.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_convert_seq_if.sv | 25 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bcd_convert_seq.sv | 124 ++++++++++++
 tb/tb_bcd_convert_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int MAX_DIGITS = 16;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Saturation pattern: 'digits' nines in the low nibbles, zero above.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] all_nines(input int digits);
    logic [DIGIT_W*MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) r[i*DIGIT_W +: DIGIT_W] = digit_t'(9);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_convert_seq_if.sv
// Start/busy/done handshake and result bus between count latch, converter and display driver.
interface bcd_convert_seq_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) ();

  logic                  start;
  logic [BIN_W-1:0]      bnum;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bnum,
    input  busy, done, bcd, overflow, blank
  );

  modport slave (
    input  start, bnum,
    output busy, done, bcd, overflow, blank
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit adjuster: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  digit_t din,
  output digit_t dout
);

  always_comb begin
    dout = din;
    if (din >= digit_t'(ADJ_THRESH)) dout = din + digit_t'(3);
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble converter: one shift/add-3 iteration per clock.
// Optional leading-zero blank mask enabled by defining BCD_LEADING_BLANK_EN.
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst,
  bcd_convert_seq_if.slave bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BIN_W + BCD_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [DIGIT_W*MAX_DIGITS-1:0] NINES_ALL = all_nines(DIGITS);
  localparam logic [BCD_W-1:0] NINES     = NINES_ALL[BCD_W-1:0];
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t             state_reg;
  logic [SR_W-1:0]    sr_reg;
  logic [CNT_W-1:0]   iter_reg;
  logic               ovf_sticky_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               overflow_reg;

  logic [SR_W-1:0]    adj_sr;
  logic [SR_W-1:0]    shift_next;
  logic               shift_out;
  logic               ovf_final;
  logic [BCD_W-1:0]   bcd_final;
  logic               last_iter;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (sr_reg[BIN_W + gi*DIGIT_W +: DIGIT_W]),
        .dout (adj_sr[BIN_W + gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign adj_sr[BIN_W-1:0] = sr_reg[BIN_W-1:0];
  assign shift_out         = adj_sr[SR_W-1];
  assign shift_next        = {adj_sr[SR_W-2:0], 1'b0};
  // The final shift can itself overflow, so fold it in before the result is latched.
  assign ovf_final         = ovf_sticky_reg | shift_out;
  assign bcd_final         = ovf_final ? NINES : shift_next[SR_W-1:BIN_W];
  assign last_iter         = (state_reg == CONV) && (iter_reg == LAST_ITER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sr_reg         <= '0;
      iter_reg       <= '0;
      ovf_sticky_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      bcd_reg        <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sr_reg         <= {{BCD_W{1'b0}}, bus.bnum};
            iter_reg       <= '0;
            ovf_sticky_reg <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= CONV;
          end
        end
        CONV: begin
          sr_reg         <= shift_next;
          iter_reg       <= iter_reg + 1'b1;
          ovf_sticky_reg <= ovf_final;
          if (last_iter) begin
            bcd_reg      <= bcd_final;
            overflow_reg <= ovf_final;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.bcd      = bcd_reg;
  assign bus.overflow = overflow_reg;

`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic [DIGITS-1:0] blank_reg;

  // Digit 0 always shows, so a zero result still displays a single "0".
  assign blank_next[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_next[gi] = !ovf_final && (bcd_final[BCD_W-1:gi*DIGIT_W] == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_reg <= '0;
    end else if (last_iter) begin
      blank_reg <= blank_next;
    end
  end

  assign bus.blank = blank_reg;
`else
  assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Randomized self-checking bench: 12-bit and 14-bit converters against an arithmetic BCD model.
module tb_bcd_convert_seq;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  bcd_convert_seq_if #(.BIN_W(12), .DIGITS(4)) if12 ();
  bcd_convert_seq_if #(.BIN_W(14), .DIGITS(4)) if14 ();

  bcd_convert_seq #(.BIN_W(12), .DIGITS(4)) u_dut12 (.clk(clk), .rst(rst), .bus(if12.slave));
  bcd_convert_seq #(.BIN_W(14), .DIGITS(4)) u_dut14 (.clk(clk), .rst(rst), .bus(if14.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, saturate to all nines past 10^digits-1.
  function automatic void model(input int v, input int digits,
                                output logic [15:0] bcd, output logic ovf,
                                output logic [3:0] blank);
    int lim;
    int p;
    lim   = 10 ** digits - 1;
    ovf   = (v > lim);
    bcd   = '0;
    blank = '0;
    p     = 1;
    for (int k = 0; k < digits; k++) begin
      bcd[k*4 +: 4] = ovf ? 4'd9 : 4'((v / p) % 10);
`ifdef BCD_LEADING_BLANK_EN
      if (k >= 1 && !ovf && (v / p) == 0) blank[k] = 1'b1;
`endif
      p = p * 10;
    end
  endfunction

  task automatic run_conv(input bit wide, input int v, input bit scramble, input string tag);
    logic [15:0] e_bcd;
    logic        e_ovf;
    logic [3:0]  e_blank;
    int          n;
    int          lat;
    bit          busy_ok;
    lat = wide ? 14 : 12;
    model(v, 4, e_bcd, e_ovf, e_blank);
    @(negedge clk);
    if (wide) begin if14.start = 1'b1; if14.bnum = 14'(v); end
    else      begin if12.start = 1'b1; if12.bnum = 12'(v); end
    @(posedge clk); #1;
    if12.start = 1'b0;
    if14.start = 1'b0;
    n       = 0;
    busy_ok = 1'b1;
    while (!(wide ? if14.done : if12.done) && n < 40) begin
      if (!(wide ? if14.busy : if12.busy)) busy_ok = 1'b0;
      if (scramble) begin
        if12.bnum = 12'($urandom);
        if14.bnum = 14'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    $display("[TB] %s bnum=%0d latency=%0d bcd=%h ovf=%0b blank=%b", tag, v, n,
             wide ? if14.bcd : if12.bcd, wide ? if14.overflow : if12.overflow,
             wide ? if14.blank : if12.blank);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy"}, 64'(busy_ok), 64'(1));
    check({tag, "_bcd"}, 64'(wide ? if14.bcd : if12.bcd), 64'(e_bcd));
    check({tag, "_ovf"}, 64'(wide ? if14.overflow : if12.overflow), 64'(e_ovf));
    check({tag, "_blank"}, 64'(wide ? if14.blank : if12.blank), 64'(e_blank));
    check({tag, "_busy_at_done"}, 64'(wide ? if14.busy : if12.busy), 64'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(wide ? if14.done : if12.done), 64'(0));
  endtask

  initial begin
    int          dones[$];
    int          n;
    bit          got_done;
    logic [15:0] bcd_seen[$];

    tests      = 0;
    failed     = 0;
    rst        = 1'b1;
    if12.start = 1'b0;
    if12.bnum  = '0;
    if14.start = 1'b0;
    if14.bnum  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(if12.busy), 64'(0));
    check("rst_done", 64'(if12.done), 64'(0));
    check("rst_bcd", 64'(if12.bcd), 64'(0));
    check("rst_ovf", 64'(if12.overflow), 64'(0));
    check("rst_blank", 64'(if12.blank), 64'(0));
    check("rst_bcd14", 64'(if14.bcd), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_conv(1'b0, 4095, 1'b0, "max12");
    run_conv(1'b0, 0, 1'b0, "zero12");
    run_conv(1'b0, 321, 1'b1, "scramble");
    run_conv(1'b1, 12000, 1'b0, "ovf14");
    run_conv(1'b1, 9999, 1'b0, "edge14");
    run_conv(1'b1, 10000, 1'b0, "over14");

    // Start held high: accepted at edge 0, again in the done cycle.
    @(negedge clk);
    if12.start = 1'b1;
    if12.bnum  = 12'd1234;
    @(posedge clk); #1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if12.done) begin
        dones.push_back(i);
        bcd_seen.push_back(if12.bcd);
      end
    end
    if12.start = 1'b0;
    $display("[TB] b2b dones=%0d", dones.size());
    check("b2b_count", 64'(dones.size()), 64'(2));
    if (dones.size() == 2) begin
      check("b2b_first", 64'(dones[0]), 64'(12));
      check("b2b_second", 64'(dones[1]), 64'(25));
      check("b2b_bcd0", 64'(bcd_seen[0]), 64'h1234);
      check("b2b_bcd1", 64'(bcd_seen[1]), 64'h1234);
    end
    n = 0;
    while (if12.busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_drain", 64'(if12.busy), 64'(0));
    @(posedge clk); #1;

    // Abort mid-conversion with reset.
    @(negedge clk);
    if12.start = 1'b1;
    if12.bnum  = 12'd999;
    @(posedge clk); #1;
    if12.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] abort busy=%0b bcd=%h", if12.busy, if12.bcd);
    check("abort_busy", 64'(if12.busy), 64'(0));
    check("abort_bcd", 64'(if12.bcd), 64'(0));
    check("abort_done", 64'(if12.done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    got_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (if12.done) got_done = 1'b1;
    end
    check("abort_nodone", 64'(got_done), 64'(0));
    run_conv(1'b0, 42, 1'b0, "after_abort");

    for (int i = 0; i < 25; i++) run_conv(1'b0, int'($urandom_range(0, 4095)), 1'($urandom), "rand12");
    for (int i = 0; i < 10; i++) run_conv(1'b1, int'($urandom_range(0, 16383)), 1'($urandom), "rand14");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
